bundle_serializer: RTL

Reader end of the parallel-bundle stream that `intermediate_buffer` chains carry. It accepts one bundle of `NUM_DATA_INPUTS` elements per valid/ready handshake and emits the elements one per cycle, in index order, on a single-element valid/ready stream. It sits at the tail of a buffered bundle path and feeds narrow consumers such as a serial accumulator or an output port. Partial bundles are supported through an element count.

---
 rtl/neural_connect_pkg.sv | 14 +
 rtl/serializer_index_counter.sv | 37 +++
 rtl/bundle_serializer.sv | 90 +++++++++
 3 files changed

// File: rtl/neural_connect_pkg.sv
// Shared types and helpers for the bundle stream path (serializer and buffer wrappers).
package neural_connect_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } serializer_state_t;

   // Bits needed to hold an element count in the range 0..n.
   function automatic int unsigned count_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/serializer_index_counter.sv
// Element index counter: synchronous load to zero, increment, terminal flag at last_value.
module serializer_index_counter #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             inc,
   input  logic [WIDTH-1:0] last_value,
   output logic [WIDTH-1:0] value,
   output logic             terminal
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = '0;
      end else if (inc) begin
         value_d = value_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value    = value_q;
   assign terminal = (value_q == last_value);

endmodule

// File: rtl/bundle_serializer.sv
// Parallel bundle to single-element stream serializer with partial-bundle count.
// Optional data_out_last port enabled by defining BUNDLE_SERIALIZER_LAST_EN.
module bundle_serializer
   import neural_connect_pkg::*;
#(
   parameter int unsigned NUM_DATA_INPUTS = 4,
   parameter int unsigned DATA_WIDTH      = 8
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        data_in_valid,
   input  logic [NUM_DATA_INPUTS-1:0][DATA_WIDTH-1:0]  data_in,
   input  logic [count_width(NUM_DATA_INPUTS)-1:0]     data_in_count,
   output logic                                        data_in_ready,
   output logic                                        data_out_valid,
   output logic [DATA_WIDTH-1:0]                       data_out,
`ifdef BUNDLE_SERIALIZER_LAST_EN
   output logic                                        data_out_last,
`endif
   input  logic                                        data_out_ready
);

   localparam int unsigned CW = count_width(NUM_DATA_INPUTS);
   localparam int unsigned IW = (NUM_DATA_INPUTS > 1) ? $clog2(NUM_DATA_INPUTS) : 1;

   serializer_state_t state_q, state_d;
   logic [NUM_DATA_INPUTS-1:0][DATA_WIDTH-1:0] bundle_q, bundle_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] eff_count;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] last_idx;
   logic          idx_terminal;
   logic          accept;
   logic          out_hs;

   assign eff_count = (data_in_count > CW'(NUM_DATA_INPUTS)) ? CW'(NUM_DATA_INPUTS)
                                                             : data_in_count;

   // count_q is at least 1 whenever SEND uses this, so the wrap in IDLE is harmless.
   assign last_idx = IW'(count_q - CW'(1));

   assign data_out_valid = (state_q == SEND);
   assign data_out       = bundle_q[idx_q];
   assign data_in_ready  = (state_q == IDLE) ||
                           ((state_q == SEND) && idx_terminal && data_out_ready);
   assign accept         = data_in_valid && data_in_ready;
   assign out_hs         = data_out_valid && data_out_ready;

`ifdef BUNDLE_SERIALIZER_LAST_EN
   assign data_out_last = data_out_valid && idx_terminal;
`endif

   serializer_index_counter #(
      .WIDTH (IW)
   ) u_index_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept),
      .inc        (out_hs && !idx_terminal),
      .last_value (last_idx),
      .value      (idx_q),
      .terminal   (idx_terminal)
   );

   always_comb begin
      state_d  = state_q;
      bundle_d = bundle_q;
      count_d  = count_q;
      if (accept) begin
         bundle_d = data_in;
         count_d  = eff_count;
         state_d  = (eff_count != '0) ? SEND : IDLE;
      end else if (out_hs && idx_terminal) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         bundle_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         bundle_q <= bundle_d;
         count_q  <= count_d;
      end
   end

endmodule
